tree_out_arbiter: RTL and testbench

- Round-robin arbiter and one-entry output register for a single tree-router output link.
- Several input controllers (parent port plus child ports) compete for the same downstream link.
- The block grants one requester per transfer, latches its packet, and presents it downstream with a valid/ready handshake.
- It sits between the input-controller steering outputs and the router output channel.

---
 rtl/tree_out_arbiter_if.sv | 27 ++
 rtl/tree_out_arbiter.sv | 126 ++++++++++++
 tb/tb_tree_out_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tree_out_arbiter_if.sv
// Handshake bundle between the input controllers, the output arbiter and the
// downstream router output channel.
// slave modport: the arbiter side. master modport: the environment side.
interface tree_out_arbiter_if #(
    parameter int unsigned WIDTH_packet = 14,
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned IDW          = 2
);
    logic [N_REQ-1:0]              in_valid;
    logic [N_REQ*WIDTH_packet-1:0] in_data;
    logic [N_REQ-1:0]              in_ready;
    logic                          out_valid;
    logic [WIDTH_packet-1:0]       out_data;
    logic                          out_ready;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, grant_id, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, grant_id, busy
    );
endinterface

// File: rtl/tree_out_arbiter.sv
// Round-robin arbiter plus one-entry output register for one tree-router output
// link. One requester is granted per transfer; its packet is latched and offered
// downstream with valid/ready. Full throughput: the register reloads on the same
// edge it drains.
// Optional macro TREE_ARB_PARENT_PRIO_EN: requester 0 (parent) always wins when
// valid and does not move the round-robin pointer; round-robin then covers only
// the children 1..N_REQ-1.
module tree_out_arbiter #(
    parameter int unsigned WIDTH_packet = 14,
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned IDW          = 2
) (
    input logic               clk,
    input logic               rst_n,
    tree_out_arbiter_if.slave bus
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH_packet-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;

    logic                    found;
    logic                    parent_win;
    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          cand;
    int unsigned             scan_idx;
    logic [WIDTH_packet-1:0] win_data;
    logic                    slot_free;
    logic                    xfer_in;
    logic                    xfer_out;

    // Reset gates slot_free so no requester sees a grant while rst_n is low.
    assign xfer_out  = (state_q == StFull) & bus.out_ready;
    assign slot_free = rst_n & ((state_q == StEmpty) | xfer_out);
    assign xfer_in   = found & slot_free;

    // Arbitration: scan from rr_ptr upward, wrapping modulo N_REQ.
    always_comb begin
        found      = 1'b0;
        parent_win = 1'b0;
        winner     = '0;
        scan_idx   = 0;
        cand       = '0;
`ifdef TREE_ARB_PARENT_PRIO_EN
        if (bus.in_valid[0]) begin
            found      = 1'b1;
            parent_win = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            cand = scan_idx[IDW-1:0];
`ifdef TREE_ARB_PARENT_PRIO_EN
            if (!found && bus.in_valid[cand] && (cand != '0)) begin
`else
            if (!found && bus.in_valid[cand]) begin
`endif
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Packet mux for the current winner.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner == i[IDW-1:0]) begin
                win_data = bus.in_data[i*WIDTH_packet +: WIDTH_packet];
            end
        end
    end

    // One-hot-or-zero accept to the winning requester.
    always_comb begin
        bus.in_ready = '0;
        if (xfer_in) begin
            bus.in_ready[winner] = 1'b1;
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer_in) begin
            state_d    = StFull;
            out_data_d = win_data;
            grant_id_d = winner;
            if (!parent_win) begin
                rr_ptr_d = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            end
        end else if (xfer_out) begin
            state_d = StEmpty;
        end
    end

    // State registers; asynchronous reset discards any buffered packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.out_valid = (state_q == StFull);
    assign bus.busy      = (state_q == StFull);
    assign bus.out_data  = out_data_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_tree_out_arbiter.sv
// Directed self-checking bench for tree_out_arbiter (N_REQ=3, 14-bit packets).
// The default build checks pure round-robin; with TREE_ARB_PARENT_PRIO_EN the
// parent-priority sequence is checked instead.
module tb_tree_out_arbiter;

    localparam int unsigned W   = 14;
    localparam int unsigned N   = 3;
    localparam int unsigned IDW = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tree_out_arbiter_if #(.WIDTH_packet(W), .N_REQ(N), .IDW(IDW)) bus ();

    tree_out_arbiter #(.WIDTH_packet(W), .N_REQ(N), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pkt(input int idx, input logic [W-1:0] val);
        bus.in_data[idx*W +: W] = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered-output check after an edge.
    task automatic chk_out(input string tag, input logic v, input logic [IDW-1:0] g,
                           input logic [W-1:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(v));
        chk({tag, "_grant"}, 32'(bus.grant_id), 32'(g));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 3'b111;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        set_pkt(0, 14'h100);
        set_pkt(1, 14'h201);
        set_pkt(2, 14'h302);

        // Reset: nothing accepted, everything cleared.
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk_out("rst", 1'b0, 2'd0, 14'h000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready_held", 32'(bus.in_ready), 32'h0);
        rst_n = 1'b1;
        #1;

`ifdef TREE_ARB_PARENT_PRIO_EN
        // Parent always wins while valid.
        chk("prio_ready0", 32'(bus.in_ready), 32'b001);
        tick(); chk_out("prio_g0a", 1'b1, 2'd0, 14'h100);
        tick(); chk_out("prio_g0b", 1'b1, 2'd0, 14'h100);
        tick(); chk_out("prio_g0c", 1'b1, 2'd0, 14'h100);
        // Parent grants left rr_ptr at 0, so children go 1,2,1.
        bus.in_valid = 3'b110;
        #1;
        chk("prio_ready1", 32'(bus.in_ready), 32'b010);
        tick(); chk_out("prio_g1", 1'b1, 2'd1, 14'h201);
        tick(); chk_out("prio_g2", 1'b1, 2'd2, 14'h302);
        tick(); chk_out("prio_g1b", 1'b1, 2'd1, 14'h201);
        bus.in_valid = 3'b000;
        tick(); chk("prio_drain", 32'(bus.out_valid), 32'h0);
`else
        // Round-robin from reset: 0,1,2,0 back to back.
        chk("rr_ready0", 32'(bus.in_ready), 32'b001);
        tick(); chk_out("rr_g0", 1'b1, 2'd0, 14'h100);
        chk("rr_ready1", 32'(bus.in_ready), 32'b010);
        tick(); chk_out("rr_g1", 1'b1, 2'd1, 14'h201);
        chk("rr_ready2", 32'(bus.in_ready), 32'b100);
        tick(); chk_out("rr_g2", 1'b1, 2'd2, 14'h302);
        tick(); chk_out("rr_g0b", 1'b1, 2'd0, 14'h100);

        // Single requester 1 (rr_ptr=1).
        bus.in_valid = 3'b010;
        set_pkt(1, 14'h2A5);
        #1;
        chk("single_ready", 32'(bus.in_ready), 32'b010);
        tick(); chk_out("single", 1'b1, 2'd1, 14'h2A5);
        bus.in_valid = 3'b000;
        tick(); chk("single_empty", 32'(bus.out_valid), 32'h0);
        chk("single_busy", 32'(bus.busy), 32'h0);

        // Back-pressure: fill with 14'h155 from requester 2 (rr_ptr -> 0).
        bus.in_valid  = 3'b100;
        bus.out_ready = 1'b0;
        set_pkt(2, 14'h155);
        tick(); chk_out("bp_fill", 1'b1, 2'd2, 14'h155);
        bus.in_valid = 3'b101;
        set_pkt(0, 14'h0AA);
        set_pkt(2, 14'h0CC);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_ready", 32'(bus.in_ready), 32'h0);
            tick(); chk_out("bp_hold", 1'b1, 2'd2, 14'h155);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'b001);
        tick(); chk_out("bp_g0", 1'b1, 2'd0, 14'h0AA);
        bus.in_valid = 3'b100;
        #1;
        chk("bp_ready2", 32'(bus.in_ready), 32'b100);
        tick(); chk_out("bp_g2", 1'b1, 2'd2, 14'h0CC);

        // Wrap-around: grant 1 leaves rr_ptr=2, then 3'b101 -> 2 then 0.
        bus.in_valid = 3'b010;
        set_pkt(1, 14'h011);
        tick(); chk_out("wrap_g1", 1'b1, 2'd1, 14'h011);
        bus.in_valid = 3'b101;
        set_pkt(0, 14'h022);
        set_pkt(2, 14'h033);
        #1;
        chk("wrap_ready2", 32'(bus.in_ready), 32'b100);
        tick(); chk_out("wrap_g2", 1'b1, 2'd2, 14'h033);
        bus.in_valid = 3'b001;
        tick(); chk_out("wrap_g0", 1'b1, 2'd0, 14'h022);
        bus.in_valid = 3'b000;
        tick(); chk("wrap_empty", 32'(bus.out_valid), 32'h0);

        // Mid-transfer reset between edges (rr_ptr is 1 before reset).
        bus.in_valid = 3'b001;
        set_pkt(0, 14'h3FF);
        tick(); chk_out("mr_fill", 1'b1, 2'd0, 14'h3FF);
        bus.in_valid  = 3'b000;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mr_async", 1'b0, 2'd0, 14'h000);
        #1;
        rst_n = 1'b1;
        tick(); chk_out("mr_after", 1'b0, 2'd0, 14'h000);
        bus.in_valid = 3'b111;
        #1;
        chk("mr_rr_reset", 32'(bus.in_ready), 32'b001);
        bus.in_valid = 3'b000;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
